mc_ctrl_fsm: RTL and testbench

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

---
 rtl/mc_ctrl_pkg.sv | 80 ++++++++
 rtl/mc_alu_dec.sv | 54 +++++
 rtl/mc_ctrl_fsm.sv | 213 +++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : Shared types and constants for the multicycle control FSM:
//                state encoding, opcodes, immediate-format codes, ALU
//                operation codes and the ALUOp class.
//  Revision    : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

    // Controller states; the 4-bit code is visible on state_o.
    typedef enum logic [3:0] {
        c_st_fetch    = 4'd0,
        c_st_decode   = 4'd1,
        c_st_memadr   = 4'd2,
        c_st_memread  = 4'd3,
        c_st_memwb    = 4'd4,
        c_st_memwrite = 4'd5,
        c_st_execr    = 4'd6,
        c_st_execi    = 4'd7,
        c_st_jalr1    = 4'd8,
        c_st_jal      = 4'd9,
        c_st_aluwb    = 4'd10,
        c_st_branch   = 4'd11,
        c_st_trap     = 4'd12,
        c_st_error    = 4'd13
    } state_t;

    // Class of ALU operation requested by the FSM; the decoder refines it.
    typedef enum logic [1:0] {
        c_aluop_add   = 2'd0,
        c_aluop_sub   = 2'd1,
        c_aluop_rtype = 2'd2,
        c_aluop_itype = 2'd3
    } aluop_t;

    // Opcodes
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_ialu   = 7'b0010011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    // Immediate formats
    localparam logic [2:0] c_imm_i = 3'b000;
    localparam logic [2:0] c_imm_s = 3'b001;
    localparam logic [2:0] c_imm_b = 3'b010;
    localparam logic [2:0] c_imm_j = 3'b011;
    localparam logic [2:0] c_imm_u = 3'b100;

    // ALU operation codes
    localparam logic [3:0] c_alu_add   = 4'd0;
    localparam logic [3:0] c_alu_sub   = 4'd1;
    localparam logic [3:0] c_alu_and   = 4'd2;
    localparam logic [3:0] c_alu_or    = 4'd3;
    localparam logic [3:0] c_alu_xor   = 4'd4;
    localparam logic [3:0] c_alu_slt   = 4'd5;
    localparam logic [3:0] c_alu_sltu  = 4'd6;
    localparam logic [3:0] c_alu_sll   = 4'd7;
    localparam logic [3:0] c_alu_srl   = 4'd8;
    localparam logic [3:0] c_alu_sra   = 4'd9;
    localparam logic [3:0] c_alu_passb = 4'd10;

    // Immediate format implied by the opcode; unknown opcodes fall to I.
    function automatic logic [2:0] imm_src_f(input logic [6:0] op);
        case (op)
            c_op_store:           imm_src_f = c_imm_s;
            c_op_branch:          imm_src_f = c_imm_b;
            c_op_jal:             imm_src_f = c_imm_j;
            c_op_lui, c_op_auipc: imm_src_f = c_imm_u;
            default:              imm_src_f = c_imm_i;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_alu_dec.sv
`default_nettype none
// ============================================================================
//  Module      : mc_alu_dec
//  Description : Combinational ALU control decoder. Maps the ALUOp class
//                from the FSM plus funct3/funct7b5/op to an ALU op code.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_alu_dec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTL_W = 4
) (
    input  aluop_t              i_aluop,
    input  logic [2:0]          i_funct3,
    input  logic                i_funct7b5,
    input  logic [6:0]          i_op,
    output logic [ALUCTL_W-1:0] o_alu_control
);

    logic [3:0] w_code;

    // Register-register ops honour funct7b5 for SUB/SRA; immediate ops only
    // for SRAI, since addi has no subtract form.
    always_comb begin
        w_code = c_alu_add;
        case (i_aluop)
            c_aluop_add: w_code = c_alu_add;
            c_aluop_sub: w_code = c_alu_sub;
            default: begin
                if (i_aluop == c_aluop_itype && i_op == c_op_lui) begin
                    w_code = c_alu_passb;
                end else if (i_aluop == c_aluop_itype && i_op == c_op_auipc) begin
                    w_code = c_alu_add;
                end else begin
                    case (i_funct3)
                        3'b000: w_code = (i_aluop == c_aluop_rtype && i_funct7b5)
                                         ? c_alu_sub : c_alu_add;
                        3'b001: w_code = c_alu_sll;
                        3'b010: w_code = c_alu_slt;
                        3'b011: w_code = c_alu_sltu;
                        3'b100: w_code = c_alu_xor;
                        3'b101: w_code = i_funct7b5 ? c_alu_sra : c_alu_srl;
                        3'b110: w_code = c_alu_or;
                        default: w_code = c_alu_and;
                    endcase
                end
            end
        endcase
    end

    assign o_alu_control = ALUCTL_W'(w_code);

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_fsm
//  Description : Multicycle RV32I control FSM with handshaked memory
//                accesses. Optional memory-wait watchdog enabled by the
//                macro MC_CTRL_TIMEOUT_EN (default build: no watchdog).
//  Revision    : 1.0  initial release
// ============================================================================
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTL_W    = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                Zero,
    input  logic                Lt,
    input  logic                Ltu,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                AdrSrc,
    output logic                PCWrite,
    output logic                illegal,
    output logic                timeout_err,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          ImmSrc,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic [3:0]          state_o
);

    state_t r_state;
    state_t w_next;
    aluop_t w_aluop;
    logic   r_illegal;
    logic   r_timeout_err;
    logic   w_wait_state;
    logic   w_timeout;
    logic   w_taken;

    assign w_wait_state = (r_state == c_st_fetch) || (r_state == c_st_memread) ||
                          (r_state == c_st_memwrite);

`ifdef MC_CTRL_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    assign w_timeout = w_wait_state && !mem_ready &&
                       (r_wait_cnt == 8'(MEM_TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^8'(MEM_TIMEOUT);
    assign w_timeout        = 1'b0;
`endif

    // Branch condition selected by funct3.
    always_comb begin
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = Zero;
            3'b001:  w_taken = !Zero;
            3'b100:  w_taken = Lt;
            3'b101:  w_taken = !Lt;
            3'b110:  w_taken = Ltu;
            3'b111:  w_taken = !Ltu;
            default: w_taken = 1'b0;
        endcase
    end

    // Next-state selection and per-state control outputs.
    always_comb begin
        w_next    = r_state;
        w_aluop   = c_aluop_add;
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        AdrSrc    = 1'b0;
        PCWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        case (r_state)
            c_st_fetch: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready)      w_next = c_st_decode;
                else if (w_timeout) w_next = c_st_error;
            end
            c_st_decode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    c_op_load, c_op_store:          w_next = c_st_memadr;
                    c_op_rtype:                     w_next = c_st_execr;
                    c_op_ialu, c_op_lui, c_op_auipc: w_next = c_st_execi;
                    c_op_jal:                       w_next = c_st_jal;
                    c_op_jalr:                      w_next = c_st_jalr1;
                    c_op_branch:
                        w_next = (funct3 == 3'b010 || funct3 == 3'b011)
                                 ? c_st_trap : c_st_branch;
                    default:                        w_next = c_st_trap;
                endcase
            end
            c_st_memadr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (op == c_op_store) ? c_st_memwrite : c_st_memread;
            end
            c_st_memread: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready)      w_next = c_st_memwb;
                else if (w_timeout) w_next = c_st_error;
            end
            c_st_memwb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                w_next    = c_st_fetch;
            end
            c_st_memwrite: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready)      w_next = c_st_fetch;
                else if (w_timeout) w_next = c_st_error;
            end
            c_st_execr: begin
                ALUSrcA = 2'b10;
                w_aluop = c_aluop_rtype;
                w_next  = c_st_aluwb;
            end
            c_st_execi: begin
                ALUSrcA = (op == c_op_auipc) ? 2'b01 : 2'b10;
                ALUSrcB = 2'b01;
                w_aluop = c_aluop_itype;
                w_next  = c_st_aluwb;
            end
            c_st_aluwb: begin
                RegWrite = 1'b1;
                w_next   = c_st_fetch;
            end
            c_st_jalr1: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = c_st_jal;
            end
            c_st_jal: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                w_next  = c_st_aluwb;
            end
            c_st_branch: begin
                ALUSrcA = 2'b10;
                w_aluop = c_aluop_sub;
                PCWrite = w_taken;
                w_next  = c_st_fetch;
            end
            c_st_trap:  w_next = c_st_trap;
            c_st_error: w_next = c_st_error;
            default:    w_next = c_st_trap;
        endcase
    end

    // State register, sticky fault flags and the optional wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_fetch;
            r_illegal     <= 1'b0;
            r_timeout_err <= 1'b0;
`ifdef MC_CTRL_TIMEOUT_EN
            r_wait_cnt    <= 8'd0;
`endif
        end else begin
            r_state       <= w_next;
            r_illegal     <= (w_next == c_st_trap);
            r_timeout_err <= (w_next == c_st_error);
`ifdef MC_CTRL_TIMEOUT_EN
            if (w_wait_state && !mem_ready && (w_next == r_state))
                r_wait_cnt <= r_wait_cnt + 8'd1;
            else
                r_wait_cnt <= 8'd0;
`endif
        end
    end

    mc_alu_dec #(
        .ALUCTL_W (ALUCTL_W)
    ) u_alu_dec (
        .i_aluop       (w_aluop),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_op          (op),
        .o_alu_control (ALUControl)
    );

    assign ImmSrc      = imm_src_f(op);
    assign illegal     = r_illegal;
    assign timeout_err = r_timeout_err;
    assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_ctrl_fsm
//  Description : Directed self-checking bench for mc_ctrl_fsm.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    localparam logic [6:0] c_lw  = 7'b0000011;
    localparam logic [6:0] c_sw  = 7'b0100011;
    localparam logic [6:0] c_r   = 7'b0110011;
    localparam logic [6:0] c_i   = 7'b0010011;
    localparam logic [6:0] c_lui = 7'b0110111;
    localparam logic [6:0] c_aui = 7'b0010111;
    localparam logic [6:0] c_jal = 7'b1101111;
    localparam logic [6:0] c_jlr = 7'b1100111;
    localparam logic [6:0] c_br  = 7'b1100011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       Lt = 1'b0;
    logic       Ltu = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, MemWrite, IRWrite, RegWrite, AdrSrc, PCWrite;
    logic       illegal, timeout_err;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic [3:0] state_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(
        .ALUCTL_W    (4),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .Zero        (Zero),
        .Lt          (Lt),
        .Ltu         (Ltu),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .AdrSrc      (AdrSrc),
        .PCWrite     (PCWrite),
        .illegal     (illegal),
        .timeout_err (timeout_err),
        .ResultSrc   (ResultSrc),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ImmSrc      (ImmSrc),
        .ALUControl  (ALUControl),
        .state_o     (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    // Issue one instruction from FETCH with mem_ready=1; count edges back to FETCH.
    task automatic lat(input string tag, input logic [6:0] o, input logic [2:0] f3,
                       input int exp);
        int n;
        set_instr(o, f3, 1'b0);
        mem_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (state_o !== 4'd0 && n < 40);
        chk(tag, n, exp);
    endtask

    initial begin
        // Reset state
        mem_ready = 1'b0;
        tick();
        do_reset();
        chk("rst_state", state_o, 4'd0);
        chk("rst_mem_req", mem_req, 1'b1);
        chk("rst_irwrite", IRWrite, 1'b0);
        chk("rst_pcwrite", PCWrite, 1'b0);
        chk("rst_regwrite", RegWrite, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        chk("fetch_srcb", ALUSrcB, 2'b10);
        chk("fetch_res", ResultSrc, 2'b10);

        // lw with two wait cycles in MEMREAD
        set_instr(c_lw, 3'b010, 1'b0);
        mem_ready = 1'b1;
        #1;
        chk("lw_irwrite", IRWrite, 1'b1);
        chk("lw_pcwrite", PCWrite, 1'b1);
        tick();
        chk("lw_decode", state_o, 4'd1);
        chk("lw_dec_srca", ALUSrcA, 2'b01);
        chk("lw_dec_srcb", ALUSrcB, 2'b01);
        tick();
        chk("lw_memadr", state_o, 4'd2);
        chk("lw_memadr_srca", ALUSrcA, 2'b10);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("lw_memread1", state_o, 4'd3);
        chk("lw_adrsrc", AdrSrc, 1'b1);
        chk("lw_rd_req", mem_req, 1'b1);
        chk("lw_rd_regwr", RegWrite, 1'b0);
        tick();
        chk("lw_memread2", state_o, 4'd3);
        tick();
        chk("lw_memread3", state_o, 4'd3);
        mem_ready = 1'b1;
        tick();
        chk("lw_memwb", state_o, 4'd4);
        chk("lw_wb_regwr", RegWrite, 1'b1);
        chk("lw_wb_res", ResultSrc, 2'b01);
        tick();
        chk("lw_done7", state_o, 4'd0);
        chk("lw_fetch_regwr", RegWrite, 1'b0);

        // Latencies with zero memory wait
        lat("lat_beq", c_br, 3'b000, 3);
        lat("lat_r", c_r, 3'b000, 4);
        lat("lat_i", c_i, 3'b000, 4);
        lat("lat_sw", c_sw, 3'b010, 4);
        lat("lat_jal", c_jal, 3'b000, 4);
        lat("lat_lw", c_lw, 3'b010, 5);
        lat("lat_jalr", c_jlr, 3'b000, 5);

        // Branch decisions (in FETCH at this point)
        set_instr(c_br, 3'b000, 1'b0); Zero = 1'b1; mem_ready = 1'b1;
        #1;
        chk("imm_b", ImmSrc, 3'b010);
        tick(); tick();
        chk("beq_state", state_o, 4'd11);
        chk("beq_pcwrite", PCWrite, 1'b1);
        chk("beq_aluctl", ALUControl, 4'd1);
        tick();
        set_instr(c_br, 3'b001, 1'b0);
        tick(); tick();
        chk("bne_pcwrite", PCWrite, 1'b0);
        tick();
        chk("bne_fetch", state_o, 4'd0);
        Zero = 1'b0; Lt = 1'b1; set_instr(c_br, 3'b100, 1'b0);
        tick(); tick();
        chk("blt_pcwrite", PCWrite, 1'b1);
        tick();
        Ltu = 1'b1; set_instr(c_br, 3'b111, 1'b0);
        tick(); tick();
        chk("bgeu_pcwrite", PCWrite, 1'b0);
        tick();
        Lt = 1'b0; Ltu = 1'b0;

        // ALU decode in EXECR / EXECI
        set_instr(c_r, 3'b000, 1'b1);
        tick(); tick();
        chk("execr_state", state_o, 4'd6);
        chk("r_sub", ALUControl, 4'd1);
        funct7b5 = 1'b0; #1;
        chk("r_add", ALUControl, 4'd0);
        set_instr(c_r, 3'b101, 1'b1); #1;
        chk("r_sra", ALUControl, 4'd9);
        tick();
        chk("aluwb_regwr", RegWrite, 1'b1);
        tick();
        set_instr(c_i, 3'b000, 1'b1);
        tick(); tick();
        chk("addi_f7", ALUControl, 4'd0);
        set_instr(c_i, 3'b101, 1'b1); #1;
        chk("srai", ALUControl, 4'd9);
        tick(); tick();
        set_instr(c_lui, 3'b000, 1'b0);
        #1;
        chk("imm_u", ImmSrc, 3'b100);
        tick(); tick();
        chk("lui_passb", ALUControl, 4'd10);
        tick(); tick();
        set_instr(c_aui, 3'b000, 1'b0);
        tick(); tick();
        chk("auipc_add", ALUControl, 4'd0);
        chk("auipc_srca", ALUSrcA, 2'b01);
        tick(); tick();
        set_instr(c_sw, 3'b010, 1'b0); #1;
        chk("imm_s", ImmSrc, 3'b001);
        set_instr(c_jal, 3'b000, 1'b0); #1;
        chk("imm_j", ImmSrc, 3'b011);

        // Reset during a store held in MEMWRITE
        set_instr(c_sw, 3'b010, 1'b0);
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        chk("sw_memwrite", state_o, 4'd5);
        chk("sw_memwr", MemWrite, 1'b1);
        do_reset();
        chk("sw_rst_state", state_o, 4'd0);
        chk("sw_rst_memwr", MemWrite, 1'b0);
        chk("sw_rst_req", mem_req, 1'b1);

        // Illegal opcode traps and stays trapped
        set_instr(7'b0000000, 3'b000, 1'b0); mem_ready = 1'b1;
        tick();
        chk("ill_decode", state_o, 4'd1);
        tick();
        chk("ill_trap", state_o, 4'd12);
        chk("ill_flag", illegal, 1'b1);
        chk("ill_req", mem_req, 1'b0);
        tick(); tick(); tick();
        chk("ill_hold", state_o, 4'd12);
        chk("ill_hold_flag", illegal, 1'b1);
        chk("ill_pcwrite", PCWrite, 1'b0);
        do_reset();
        chk("ill_clear", illegal, 1'b0);
        set_instr(c_br, 3'b010, 1'b0);
        tick(); tick();
        chk("br010_trap", state_o, 4'd12);
        do_reset();

        // Memory wait in FETCH
        mem_ready = 1'b0;
        tick(); tick(); tick();
        chk("to_wait3", state_o, 4'd0);
`ifdef MC_CTRL_TIMEOUT_EN
        tick();
        chk("to_error", state_o, 4'd13);
        chk("to_flag", timeout_err, 1'b1);
        chk("to_req", mem_req, 1'b0);
        tick();
        chk("to_hold", state_o, 4'd13);
        do_reset();
        chk("to_clear", timeout_err, 1'b0);
`else
        for (int k = 0; k < 20; k++) tick();
        chk("nowd_fetch", state_o, 4'd0);
        chk("nowd_flag", timeout_err, 1'b0);
        chk("nowd_req", mem_req, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
